// File: rtl/pipe_pkg.sv
// Shared constants for the arithmetic pipeline and its result collector,
// plus the FIFO operation encoding used by the collector's buffer.
package pipe_pkg;

   localparam int PIPE_LAT    = 3;
   localparam int PIPE_DATA_W = 21;
   localparam int PIPE_IN_W   = 10;
   localparam int COLL_DEPTH  = 4;
   localparam int COLL_CNT_W  = $clog2(COLL_DEPTH + 1);

   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_PUSH = 2'b01,
      FIFO_POP  = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/pipe_collector_if.sv
// Capture/read bundle of the pipeline collector. The master drives the
// pipeline-side and reader-side requests; the slave returns data and status.
interface pipe_collector_if #(
   parameter int DATA_W = 21,
   parameter int CNT_W  = 3
);
   logic              in_valid;
   logic [DATA_W-1:0] piped_out;
   logic              rd_en;
   logic              clr_ovf;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output in_valid, piped_out, rd_en, clr_ovf,
      input  rd_data, rd_valid, empty, full, count, overflow
   );

   modport slave (
      input  in_valid, piped_out, rd_en, clr_ovf,
      output rd_data, rd_valid, empty, full, count, overflow
   );
endinterface

// File: rtl/pipe_collector_sync_fifo.sv
// DEPTH x DATA_W synchronous FIFO with a registered read port. A write into a
// full FIFO is taken only when a pop frees a slot in the same cycle.
module sync_fifo
   import pipe_pkg::*;
#(
   parameter int DATA_W = 21,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              pop_s, wr_ok_s;
   fifo_op_e          op_s;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == {CNT_W{1'b0}});
   assign pop_s   = rd_req & ~empty;
   assign wr_ok_s = wr_req & (~full | pop_s);
   assign op_s    = fifo_op_e'({pop_s, wr_ok_s});

   // Next-state for storage, pointers, occupancy and the read port.
   always_comb begin
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      case (op_s)
         FIFO_IDLE: begin
            count_d = count_q;
         end
         FIFO_PUSH: begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + PTR_W'(1);
            count_d       = count_q + CNT_W'(1);
         end
         FIFO_POP: begin
            rd_data_d  = mem_q[rptr_q];
            rd_valid_d = 1'b1;
            rptr_d     = rptr_q + PTR_W'(1);
            count_d    = count_q - CNT_W'(1);
         end
         FIFO_BOTH: begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + PTR_W'(1);
            rd_data_d     = mem_q[rptr_q];
            rd_valid_d    = 1'b1;
            rptr_d        = rptr_q + PTR_W'(1);
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
endmodule

// File: rtl/pipe_collector.sv
// Receiving end of the arithmetic pipeline: tracks injected operand sets with
// a LAT-deep valid delay line and buffers each emerging result in a FIFO.
module pipe_collector
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int LAT    = PIPE_LAT,
   parameter int DEPTH  = COLL_DEPTH,
   parameter int CNT_W  = COLL_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_collector_if.slave   bus
);
   logic [LAT-1:0] vld_sr_q, vld_sr_d;
   logic           ovf_q, ovf_d;
   logic           cap_s, drop_s;
   logic           full_s;

   assign cap_s = vld_sr_q[LAT-1];
   // A full FIFO is never empty, so rd_en alone tells whether a slot frees up.
   assign drop_s = cap_s & full_s & ~bus.rd_en;

   // Valid delay line and sticky overflow next-state; a drop beats a clear.
   always_comb begin
      vld_sr_d    = vld_sr_q;
      vld_sr_d[0] = bus.in_valid;
      for (int i = 1; i < LAT; i++) vld_sr_d[i] = vld_sr_q[i-1];
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Collector state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         vld_sr_q <= vld_sr_d;
         ovf_q    <= ovf_d;
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_req   (cap_s),
      .rd_req   (bus.rd_en),
      .wdata    (bus.piped_out),
      .rd_data  (bus.rd_data),
      .rd_valid (bus.rd_valid),
      .count    (bus.count),
      .full     (full_s),
      .empty    (bus.empty)
   );

   assign bus.full     = full_s;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_pipe_collector.sv
// Directed bench for pipe_collector: a LAT-stage model of the pipeline feeds
// piped_out, and every check compares against hand-computed values.
module tb_pipe_collector;
   localparam int DATA_W = 21;
   localparam int LAT    = 3;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [DATA_W-1:0] in_val = '0;
   logic [DATA_W-1:0] pipe_q [LAT];
   int checks = 0;
   int errors = 0;

   pipe_collector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

   pipe_collector #(
      .DATA_W (DATA_W),
      .LAT    (LAT),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < LAT; i++) pipe_q[i] = '0;

   always @(posedge clk) begin
      pipe_q[0] <= in_val;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
   end
   assign bus_if.piped_out = pipe_q[LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [DATA_W-1:0] v);
      bus_if.in_valid = 1'b1;
      in_val = v;
      tick();
      bus_if.in_valid = 1'b0;
   endtask

   task automatic read_exp(input string tag, input logic [DATA_W-1:0] v);
      bus_if.rd_en = 1'b1;
      tick();
      chk({tag, "_vld"}, 32'(bus_if.rd_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus_if.rd_data), 32'(v));
   endtask

   initial begin
      bus_if.in_valid = 1'b1;
      bus_if.rd_en    = 1'b1;
      bus_if.clr_ovf  = 1'b0;
      repeat (3) tick();
      chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
      chk("rst_rd_data", 32'(bus_if.rd_data), 32'd0);
      chk("rst_empty", 32'(bus_if.empty), 32'd1);
      chk("rst_full", 32'(bus_if.full), 32'd0);
      chk("rst_count", 32'(bus_if.count), 32'd0);
      chk("rst_ovf", 32'(bus_if.overflow), 32'd0);
      bus_if.in_valid = 1'b0;
      bus_if.rd_en    = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("post_rst_count", 32'(bus_if.count), 32'd0);

      // single result: captured LAT edges after issue
      issue(21'd9);
      tick();
      tick();
      chk("lat_early_count", 32'(bus_if.count), 32'd0);
      tick();
      chk("single_count", 32'(bus_if.count), 32'd1);
      chk("single_empty", 32'(bus_if.empty), 32'd0);
      read_exp("single_rd", 21'd9);
      bus_if.rd_en = 1'b0;
      chk("single_count0", 32'(bus_if.count), 32'd0);
      chk("single_empty1", 32'(bus_if.empty), 32'd1);
      tick();
      chk("single_vld_pulse", 32'(bus_if.rd_valid), 32'd0);
      chk("single_hold", 32'(bus_if.rd_data), 32'd9);

      // stream of three, read back with no bubbles
      issue(21'd9);
      issue(21'd54);
      issue(21'd135);
      repeat (3) tick();
      chk("stream_count", 32'(bus_if.count), 32'd3);
      read_exp("stream_rd0", 21'd9);
      read_exp("stream_rd1", 21'd54);
      read_exp("stream_rd2", 21'd135);
      bus_if.rd_en = 1'b0;
      tick();
      chk("stream_vld0", 32'(bus_if.rd_valid), 32'd0);
      chk("stream_empty", 32'(bus_if.empty), 32'd1);

      // overflow: 5 captures into 4 slots
      for (int v = 1; v <= 5; v++) issue(21'(v));
      tick();
      tick();
      chk("ovf_full", 32'(bus_if.full), 32'd1);
      chk("ovf_count4", 32'(bus_if.count), 32'd4);
      chk("ovf_not_yet", 32'(bus_if.overflow), 32'd0);
      tick();
      chk("ovf_set", 32'(bus_if.overflow), 32'd1);
      chk("ovf_count_hold", 32'(bus_if.count), 32'd4);
      for (int v = 1; v <= 4; v++) read_exp("ovf_rd", 21'(v));
      bus_if.rd_en = 1'b0;
      chk("ovf_drained", 32'(bus_if.empty), 32'd1);

      // wrap with 6..9, drop of 10 coinciding with clr_ovf: set wins
      for (int v = 6; v <= 10; v++) issue(21'(v));
      tick();
      tick();
      chk("wrap_full", 32'(bus_if.full), 32'd1);
      bus_if.clr_ovf = 1'b1;
      tick();
      bus_if.clr_ovf = 1'b0;
      chk("ovf_set_wins", 32'(bus_if.overflow), 32'd1);
      for (int v = 6; v <= 9; v++) read_exp("wrap_rd", 21'(v));
      bus_if.rd_en = 1'b0;
      chk("wrap_empty", 32'(bus_if.empty), 32'd1);
      bus_if.clr_ovf = 1'b1;
      tick();
      bus_if.clr_ovf = 1'b0;
      chk("ovf_cleared", 32'(bus_if.overflow), 32'd0);

      // push and pop together while full
      for (int v = 3; v <= 7; v++) issue(21'(v));
      tick();
      tick();
      chk("pp_full", 32'(bus_if.count), 32'd4);
      read_exp("pp_rd3", 21'd3);
      chk("pp_count", 32'(bus_if.count), 32'd4);
      chk("pp_no_ovf", 32'(bus_if.overflow), 32'd0);
      for (int v = 4; v <= 7; v++) read_exp("pp_rd", 21'(v));
      bus_if.rd_en = 1'b0;
      chk("pp_empty", 32'(bus_if.empty), 32'd1);

      // read while empty is ignored
      bus_if.rd_en = 1'b1;
      tick();
      bus_if.rd_en = 1'b0;
      chk("empty_rd_vld", 32'(bus_if.rd_valid), 32'd0);
      chk("empty_rd_hold", 32'(bus_if.rd_data), 32'd7);
      chk("empty_rd_count", 32'(bus_if.count), 32'd0);

      // reset with 2 buffered and 1 in flight
      issue(21'd11);
      issue(21'd12);
      issue(21'd13);
      tick();
      tick();
      chk("mid_count2", 32'(bus_if.count), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(bus_if.count), 32'd0);
      chk("mid_rst_empty", 32'(bus_if.empty), 32'd1);
      #2;
      rst_n = 1'b1;
      repeat (3) tick();
      chk("mid_no_capture", 32'(bus_if.count), 32'd0);
      chk("mid_rd_data", 32'(bus_if.rd_data), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
